afifo_rd_packer: RTL and testbench
==================================

// Module: afifo_rd_packer
// PURPOSE
//  Read-side consumer of the AFIFO, in the rclk domain. Pops DATASIZE-bit entries
//  whenever the FIFO is non-empty and packs PACK of them into one wide word.
//  Presents each word on a valid/ready output port. A partial word is emitted on
//  flush, or on an idle timeout when the timeout feature is compiled in.
// PARAMETERS
//  DATASIZE  8   width of one FIFO entry (matches AFIFO DATASIZE)
//  PACK      4   entries per output word (>=2); lane counter width = $clog2(PACK)+1
//  TIMEOUT   16  idle rclk cycles before auto-flush (PACK_TIMEOUT_EN only; >=1)
// PORTS
//  rclk       in   1                rising-edge clock (AFIFO read clock)
//  rrst       in   1                synchronous reset, active-high
//  rdata      in   DATASIZE         AFIFO read data; show-ahead, valid while rempty=0
//  rempty     in   1                AFIFO empty flag
//  rpop       out  1                AFIFO pop; combinational
//  flush      in   1                emit current partial word
//  out_data   out  DATASIZE*PACK    packed word; entry 0 in LSBs
//  out_keep   out  PACK             per-lane valid mask; bit i covers lane i
//  out_valid  out  1                word available
//  out_ready  in   1                sink accepts word when out_valid & out_ready
// BEHAVIOUR
//  - Reset (rrst=1 at rclk edge): state=IDLE, cnt=0, out_data=0, out_keep=0, out_valid=0.
//    rpop=0 while rrst=1. Lanes filled before reset are discarded; entries already
//    popped are lost; out_valid drops on the reset edge.
//  - FSM states: IDLE (cnt=0), FILL (0<cnt<PACK), HOLD (out_valid=1).
//  - rpop = !rrst & !rempty & (state!=HOLD | out_ready) & !flush_take.
//    On a pop, rdata is written into lane cnt and cnt increments.
//  - IDLE -> FILL on a pop. In FILL, the pop that fills lane PACK-1 moves to HOLD
//    on the same edge with out_keep = all ones. Latency: last entry popped ->
//    out_valid=1 on the next cycle.
//  - HOLD: out_data and out_keep stay stable until out_valid & out_ready.
//    * Accept with rempty=0: the same edge pops into lane 0 and goes to FILL with
//      cnt=1 (PACK=1 is not supported). Steady-state throughput: one word per PACK cycles.
//    * Accept with rempty=1: goes to IDLE and clears out_keep.
//  - flush_take = flush & state==FILL. On that edge: no pop, go to HOLD,
//    out_keep = (1<<cnt)-1, unfilled lanes of out_data = 0, cnt=0.
//    flush in IDLE or HOLD is ignored and is not queued.
//  - Full/empty: rempty=1 means no pop and state holds. AFIFO wfull is not observed.
//  - No combinational path from out_ready to out_data or out_valid.
// CONFIGURATION
//  PACK_TIMEOUT_EN defined:
//   - Idle counter counts rclk cycles with state==FILL & rempty=1. It clears on any
//     pop and on leaving FILL.
//   - When the counter reaches TIMEOUT, an internal flush equal to flush_take is
//     applied on the next edge.
//  PACK_TIMEOUT_EN undefined:
//   - No counter and no timeout logic.
//   - A partial word is emitted only by an external flush; otherwise it waits for
//     more data indefinitely.
// TESTING
//  1. Reset: hold rrst 2 cycles with rempty=0 -> rpop=0, out_valid=0, out_keep=0.
//  2. Full pack: FIFO pre-loaded with 8'h01..8'h08, out_ready=1 ->
//     words 32'h04030201 then 32'h08070605, keep=4'hF, no pop gap at word boundaries.
//  3. Backpressure: 8 entries loaded, out_ready=0 -> exactly 4 pops,
//     out_data held at 32'h04030201; raise out_ready -> remaining 4 entries drain.
//  4. Flush: pop 8'hAA, 8'hBB, then flush=1 with rempty=0 -> no pop that cycle,
//     out_data=32'h0000BBAA, keep=4'b0011. flush in IDLE -> no output.
//  5. Timeout (PACK_TIMEOUT_EN, TIMEOUT=16): one entry 8'h5C then FIFO empty ->
//     out_valid rises 17 cycles after the pop, keep=4'b0001. Macro undefined -> no output.
//  6. Reset mid-fill: after 2 pops, assert rrst -> cnt=0; next 4 entries form a
//     complete word with no stale lanes.

Source files
------------

// File: rtl/afifo_rd_packer.sv
// Read-side AFIFO consumer: packs PACK entries of DATASIZE bits into one word on a valid/ready port.
// Define PACK_TIMEOUT_EN to auto-flush a partial word after TIMEOUT idle cycles in FILL.
module afifo_rd_packer #(
  parameter int DATASIZE = 8,
  parameter int PACK     = 4,
  parameter int TIMEOUT  = 16
) (
  input  logic                     rclk,
  input  logic                     rrst,
  input  logic [DATASIZE-1:0]      rdata,
  input  logic                     rempty,
  output logic                     rpop,
  input  logic                     flush,
  output logic [DATASIZE*PACK-1:0] out_data,
  output logic [PACK-1:0]          out_keep,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [1:0]               dbg_state
);

  localparam int CW = $clog2(PACK) + 1;
  localparam int OW = DATASIZE * PACK;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [OW-1:0]   data_q;
  logic [PACK-1:0] keep_q;
  logic            valid_q;

  logic            flush_take;
  logic            tmo_fire;
  logic [OW-1:0]   data_fill_d;
  logic [OW-1:0]   first_word_d;
  logic [PACK-1:0] keep_part_d;

`ifdef PACK_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] idle_q;

  assign tmo_fire = (state_q == FILL) && (idle_q == TW'(TIMEOUT));

  always_ff @(posedge rclk) begin
    if (rrst || (state_q != FILL) || rpop || flush_take) begin
      idle_q <= '0;
    end else if (rempty && (idle_q != TW'(TIMEOUT))) begin
      idle_q <= idle_q + 1'b1;
    end
  end
`else
  assign tmo_fire = 1'b0;
`endif

  assign flush_take = (state_q == FILL) && (flush || tmo_fire);
  assign rpop = !rrst && !rempty && ((state_q != HOLD) || out_ready) && !flush_take;

  // Starting a word zero-extends lane 0, so lanes never written stay zero on a flush.
  assign first_word_d = OW'(rdata);

  always_comb begin
    data_fill_d = data_q;
    keep_part_d = '0;
    for (int i = 0; i < PACK; i++) begin
      if (cnt_q == CW'(i)) begin
        data_fill_d[i*DATASIZE +: DATASIZE] = rdata;
      end
      keep_part_d[i] = (CW'(i) < cnt_q);
    end
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      keep_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (rpop) begin
            data_q  <= first_word_d;
            cnt_q   <= CW'(1);
            state_q <= FILL;
          end
        end
        FILL: begin
          if (flush_take) begin
            keep_q  <= keep_part_d;
            valid_q <= 1'b1;
            cnt_q   <= '0;
            state_q <= HOLD;
          end else if (rpop) begin
            data_q <= data_fill_d;
            if (cnt_q == CW'(PACK - 1)) begin
              keep_q  <= '1;
              valid_q <= 1'b1;
              cnt_q   <= '0;
              state_q <= HOLD;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            valid_q <= 1'b0;
            keep_q  <= '0;
            if (rpop) begin
              data_q  <= first_word_d;
              cnt_q   <= CW'(1);
              state_q <= FILL;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          valid_q <= 1'b0;
          keep_q  <= '0;
        end
      endcase
    end
  end

  assign out_data  = data_q;
  assign out_keep  = keep_q;
  assign out_valid = valid_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_afifo_rd_packer.sv
// Bench for afifo_rd_packer: directed vector table, corner sequences and randomized traffic vs a lane-queue model.
module tb_afifo_rd_packer;

  localparam int DW  = 8;
  localparam int PK  = 4;
  localparam int TMO = 16;
  localparam int OW  = DW * PK;

  logic          rclk = 1'b0;
  logic          rrst;
  logic [DW-1:0] rdata;
  logic          rempty;
  logic          rpop;
  logic          flush;
  logic [OW-1:0] out_data;
  logic [PK-1:0] out_keep;
  logic          out_valid;
  logic          out_ready;
  logic [1:0]    dbg_state;

  always #5 rclk = ~rclk;

  afifo_rd_packer #(.DATASIZE(DW), .PACK(PK), .TIMEOUT(TMO)) dut (
    .rclk(rclk), .rrst(rrst), .rdata(rdata), .rempty(rempty), .rpop(rpop),
    .flush(flush), .out_data(out_data), .out_keep(out_keep), .out_valid(out_valid),
    .out_ready(out_ready), .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] fifo[$];
  logic [OW-1:0] exp_q[$];

  // Reference model: collected lanes plus the word currently offered.
  logic [DW-1:0] m_lanes[$];
  bit            m_hold = 0;
  logic [OW-1:0] m_word = '0;
  logic [PK-1:0] m_keep = '0;
  int            m_idle = 0;
  logic          last_pop;
  int            pop_count = 0;

  typedef struct {
    bit            push_en;
    logic [DW-1:0] push_val;
    bit            rst;
    bit            fl;
    bit            rdy;
    bit            e_pop;
    bit            e_valid;
    logic [PK-1:0] e_keep;
    logic [OW-1:0] e_data;
  } vec_t;

  vec_t tv[17];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic bit m_fill();
    return !m_hold && (m_lanes.size() > 0);
  endfunction

  function automatic bit m_ftake(input bit rst, input bit fl);
    bit t;
    t = fl;
`ifdef PACK_TIMEOUT_EN
    if (m_idle >= TMO) t = 1'b1;
`endif
    return !rst && m_fill() && t;
  endfunction

  function automatic bit m_pop(input bit rst, input bit fl, input bit rdy, input bit emp);
    return !rst && !emp && (!m_hold || rdy) && !m_ftake(rst, fl);
  endfunction

  task automatic m_seal();
    logic [OW-1:0] w;
    w = '0;
    for (int i = 0; i < m_lanes.size(); i++) w[i*DW +: DW] = m_lanes[i];
    m_word = w;
    m_keep = PK'((1 << m_lanes.size()) - 1);
    m_hold = 1'b1;
    exp_q.push_back(w);
    m_lanes.delete();
  endtask

  task automatic m_step(input bit rst, input bit fl, input bit rdy, input bit emp,
                        input logic [DW-1:0] d);
    bit p;
    bit ft;
    p  = m_pop(rst, fl, rdy, emp);
    ft = m_ftake(rst, fl);
    if (rst) begin
      m_lanes.delete();
      exp_q.delete();
      m_hold = 1'b0;
      m_keep = '0;
      m_word = '0;
      m_idle = 0;
    end else if (m_hold && rdy) begin
      m_hold = 1'b0;
      m_keep = '0;
      m_idle = 0;
      if (p) m_lanes.push_back(d);
    end else if (ft) begin
      m_seal();
      m_idle = 0;
    end else if (p) begin
      m_lanes.push_back(d);
      m_idle = 0;
      if (m_lanes.size() == PK) m_seal();
    end else if (m_fill() && emp) begin
      m_idle++;
    end
  endtask

  // One rclk cycle, entered and left on a falling edge.
  task automatic tick(input bit rst, input bit fl, input bit rdy);
    bit            emp;
    logic [DW-1:0] d;
    rrst      = rst;
    flush     = fl;
    out_ready = rdy;
    rempty    = (fifo.size() == 0);
    rdata     = rempty ? '0 : fifo[0];
    #1;
    emp = rempty;
    d   = rdata;
    chk("rpop", rpop, m_pop(rst, fl, rdy, emp));
    last_pop = rpop;
    if (rpop) pop_count++;
    if (out_valid && rdy && !rst) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL accepted_word: got %0h, expected no word offered", out_data);
      end else begin
        chk("accepted_word", out_data, exp_q.pop_front());
      end
    end
    @(posedge rclk);
    if (last_pop && fifo.size() > 0) void'(fifo.pop_front());
    m_step(rst, fl, rdy, emp, d);
    @(negedge rclk);
    chk("out_valid", out_valid, m_hold);
    chk("out_keep", out_keep, m_hold ? m_keep : '0);
    if (m_hold) chk("out_data", out_data, m_word);
    if (rst) chk("out_data_reset", out_data, '0);
  endtask

  initial begin
    int first;
    int pct;
    rrst = 1'b1; flush = 1'b0; out_ready = 1'b0; rempty = 1'b1; rdata = '0;
    @(negedge rclk);

    // Reset with a non-empty FIFO must not pop.
    fifo.push_back(8'hDE); fifo.push_back(8'hAD);
    tick(1, 0, 0);
    chk("t1_rpop_c0", last_pop, 1'b0);
    tick(1, 0, 0);
    chk("t1_rpop_c1", last_pop, 1'b0);
    fifo.delete();
    tick(0, 0, 0);

    // Full packs then flush corner cases.
    tv[0]  = '{0, 8'h00, 0, 0, 1, 1, 0, 4'h0, 32'h0};
    tv[1]  = '{0, 8'h00, 0, 0, 1, 1, 0, 4'h0, 32'h0};
    tv[2]  = '{0, 8'h00, 0, 0, 1, 1, 0, 4'h0, 32'h0};
    tv[3]  = '{0, 8'h00, 0, 0, 1, 1, 1, 4'hF, 32'h04030201};
    tv[4]  = '{0, 8'h00, 0, 0, 1, 1, 0, 4'h0, 32'h0};
    tv[5]  = '{0, 8'h00, 0, 0, 1, 1, 0, 4'h0, 32'h0};
    tv[6]  = '{0, 8'h00, 0, 0, 1, 1, 0, 4'h0, 32'h0};
    tv[7]  = '{0, 8'h00, 0, 0, 1, 1, 1, 4'hF, 32'h08070605};
    tv[8]  = '{0, 8'h00, 0, 0, 1, 0, 0, 4'h0, 32'h0};
    tv[9]  = '{1, 8'hAA, 0, 0, 0, 1, 0, 4'h0, 32'h0};
    tv[10] = '{1, 8'hBB, 0, 0, 0, 1, 0, 4'h0, 32'h0};
    tv[11] = '{1, 8'hCC, 0, 1, 0, 0, 1, 4'h3, 32'h0000BBAA};
    tv[12] = '{0, 8'h00, 0, 0, 1, 1, 0, 4'h0, 32'h0};
    tv[13] = '{0, 8'h00, 0, 1, 0, 0, 1, 4'h1, 32'h000000CC};
    tv[14] = '{0, 8'h00, 0, 0, 1, 0, 0, 4'h0, 32'h0};
    tv[15] = '{0, 8'h00, 0, 1, 0, 0, 0, 4'h0, 32'h0};
    tv[16] = '{0, 8'h00, 0, 0, 0, 0, 0, 4'h0, 32'h0};
    for (int i = 1; i <= 8; i++) fifo.push_back(DW'(i));
    for (int i = 0; i < 17; i++) begin
      if (tv[i].push_en) fifo.push_back(tv[i].push_val);
      tick(tv[i].rst, tv[i].fl, tv[i].rdy);
      chk($sformatf("vec%0d_pop", i), last_pop, tv[i].e_pop);
      chk($sformatf("vec%0d_valid", i), out_valid, tv[i].e_valid);
      chk($sformatf("vec%0d_keep", i), out_keep, tv[i].e_keep);
      if (tv[i].e_valid) chk($sformatf("vec%0d_data", i), out_data, tv[i].e_data);
    end

    // Backpressure: only one word's worth is popped while the sink stalls.
    for (int i = 1; i <= 8; i++) fifo.push_back(DW'(i));
    pop_count = 0;
    for (int i = 0; i < 10; i++) tick(0, 0, 0);
    chk("bp_pops", pop_count, 4);
    chk("bp_held_data", out_data, 32'h04030201);
    for (int i = 0; i < 8; i++) tick(0, 0, 1);
    chk("bp_drain_pops", pop_count, 8);
    chk("bp_fifo_empty", fifo.size(), 0);

    // Idle timeout on a single-entry partial word.
    fifo.push_back(8'h5C);
    tick(0, 0, 0);
    first = 0;
    for (int k = 1; k <= 40; k++) begin
      tick(0, 0, 0);
      if (out_valid && first == 0) first = k;
    end
`ifdef PACK_TIMEOUT_EN
    chk("tmo_latency", first, 17);
`else
    chk("tmo_none", first, 0);
    tick(0, 1, 0);
`endif
    chk("tmo_keep", out_keep, 4'b0001);
    chk("tmo_data", out_data, 32'h0000005C);
    tick(0, 0, 1);

    // Reset mid-fill discards collected lanes.
    fifo.push_back(8'h11); fifo.push_back(8'h22);
    tick(0, 0, 0);
    tick(0, 0, 0);
    fifo.push_back(8'h33); fifo.push_back(8'h44); fifo.push_back(8'h55); fifo.push_back(8'h66);
    tick(1, 0, 0);
    chk("rst_mid_pop", last_pop, 1'b0);
    for (int i = 0; i < 4; i++) tick(0, 0, 0);
    chk("rst_mid_data", out_data, 32'h66554433);
    chk("rst_mid_keep", out_keep, 4'hF);
    tick(0, 0, 1);

    // Randomized traffic against the model.
    pct = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) pct = $urandom_range(0, 100);
      if ($urandom_range(0, 99) < pct && fifo.size() < 16) fifo.push_back(DW'($urandom_range(0, 255)));
      tick($urandom_range(0, 499) == 0, $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 60);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
